sat_step_arbiter: RTL and testbench

- Owns a WIDTH-bit saturating level register.
- Two requesters (A, B) share one saturating increment/decrement step unit, and each requests one step at a time.
- A round-robin arbiter grants one request per grant cycle.
- An optional hold-off period between steps rate-limits changes.
- Sits above the combinational saturating inc/dec datapath and sequences it.

---
 rtl/sat_step_pkg.sv | 26 ++
 rtl/sat_step.sv | 43 ++++
 rtl/sat_step_arbiter.sv | 146 ++++++++++++++
 tb/tb_sat_step_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sat_step_pkg.sv
//------------------------------------------------------------------------------
// Module   : sat_step_pkg
// Purpose  : Shared types and constants for the saturating step arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sat_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

  typedef enum logic {
    REQ_ID_A = 1'b0,
    REQ_ID_B = 1'b1
  } req_id_t;

endpackage

`default_nettype wire

// File: rtl/sat_step.sv
//------------------------------------------------------------------------------
// Module   : sat_step
// Purpose  : Combinational saturating +1/-1 step on an unsigned level.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_step
  import sat_step_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic [WIDTH-1:0] level,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             clipped
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

  always_comb begin
    next    = level;
    clipped = 1'b0;
    if (dir == DIR_INC) begin
      if (level < c_max) begin
        next = level + 1'b1;
      end else begin
        next    = c_max;
        clipped = 1'b1;
      end
    end else begin
      if (level != '0) begin
        next = level - 1'b1;
      end else begin
        clipped = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sat_step_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sat_step_arbiter
// Purpose  : Round-robin arbitration of two step requesters onto one saturating
//            level register, with a hold-off between steps.
//            Optional clipped-step counter: SAT_STEP_ARBITER_SATCNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_step_arbiter
  import sat_step_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 15,
  parameter int RESET_VAL = 0,
  parameter int HOLDOFF   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             dir_a,
  input  logic             req_b,
  input  logic             dir_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] level,
  output logic             at_min,
  output logic             at_max,
  output logic             busy,
  output logic             sat
`ifdef SAT_STEP_ARBITER_SATCNT_EN
  ,
  output logic [7:0]       satcnt
`endif
);

  localparam logic [WIDTH-1:0] c_max       = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_reset     = WIDTH'(RESET_VAL);
  localparam logic [7:0]       c_hold_load = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t           r_state;
  req_id_t          r_ptr;
  logic             r_dir;
  logic [7:0]       r_hold;
  logic [WIDTH-1:0] r_level;
  logic             r_ack_a;
  logic             r_ack_b;
  logic             r_sat;

  req_id_t          w_winner;
  logic             w_win_dir;
  logic [WIDTH-1:0] w_next;
  logic             w_clipped;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    w_winner = REQ_ID_B;
    if (req_a && req_b) begin
      w_winner = r_ptr;
    end else if (req_a) begin
      w_winner = REQ_ID_A;
    end
    w_win_dir = (w_winner == REQ_ID_A) ? dir_a : dir_b;
  end

  sat_step #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .level   (r_level),
    .dir     (r_dir),
    .next    (w_next),
    .clipped (w_clipped)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= REQ_ID_A;
      r_dir   <= DIR_DEC;
      r_hold  <= '0;
      r_level <= c_reset;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_sat   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_a || req_b) begin
            r_state <= GRANT;
            r_dir   <= w_win_dir;
            r_ack_a <= (w_winner == REQ_ID_A);
            r_ack_b <= (w_winner == REQ_ID_B);
            r_ptr   <= (w_winner == REQ_ID_A) ? REQ_ID_B : REQ_ID_A;
          end
        end
        GRANT: begin
          r_level <= w_next;
          r_sat   <= w_clipped;
          if (HOLDOFF > 0) begin
            r_state <= HOLD;
            r_hold  <= c_hold_load;
          end else begin
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (r_hold == '0) begin
            r_state <= IDLE;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SAT_STEP_ARBITER_SATCNT_EN
  logic [7:0] r_satcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_satcnt <= '0;
    end else if ((r_state == GRANT) && w_clipped && (r_satcnt != 8'hFF)) begin
      r_satcnt <= r_satcnt + 1'b1;
    end
  end

  assign satcnt = r_satcnt;
`endif

  assign ack_a  = r_ack_a;
  assign ack_b  = r_ack_b;
  assign level  = r_level;
  assign sat    = r_sat;
  assign busy   = (r_state != IDLE);
  assign at_min = (r_level == '0);
  assign at_max = (r_level == c_max);

endmodule

`default_nettype wire

// File: tb/tb_sat_step_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_sat_step_arbiter
// Purpose  : Self-checking bench: per-cycle vector table with an expectation
//            queue, plus a hold-off-0 contention sequence on a second instance.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sat_step_arbiter;

  typedef struct {
    int         idx;
    logic       rst_n;
    logic       ra;
    logic       da;
    logic       rb;
    logic       db;
    logic       ack_a;
    logic       ack_b;
    logic [3:0] level;
    logic       busy;
    logic       sat;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with HOLDOFF = 2 (table driven)
  logic       rst_n = 1'b0, req_a = 1'b0, dir_a = 1'b0, req_b = 1'b0, dir_b = 1'b0;
  logic       ack_a, ack_b, at_min, at_max, busy, sat;
  logic [3:0] level;
  logic [7:0] satcnt_v;

  // Instance with HOLDOFF = 0 (hand sequence)
  logic       rst_n0 = 1'b0, req_a0 = 1'b0, dir_a0 = 1'b0, req_b0 = 1'b0, dir_b0 = 1'b0;
  logic       ack_a0, ack_b0, at_min0, at_max0, busy0, sat0;
  logic [3:0] level0;
  logic [7:0] satcnt0_v;

  sat_step_arbiter #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0), .HOLDOFF(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .dir_a(dir_a), .req_b(req_b), .dir_b(dir_b),
    .ack_a(ack_a), .ack_b(ack_b), .level(level), .at_min(at_min), .at_max(at_max),
    .busy(busy), .sat(sat)
`ifdef SAT_STEP_ARBITER_SATCNT_EN
    , .satcnt(satcnt_v)
`endif
  );

  sat_step_arbiter #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .req_a(req_a0), .dir_a(dir_a0), .req_b(req_b0), .dir_b(dir_b0),
    .ack_a(ack_a0), .ack_b(ack_b0), .level(level0), .at_min(at_min0), .at_max(at_max0),
    .busy(busy0), .sat(sat0)
`ifdef SAT_STEP_ARBITER_SATCNT_EN
    , .satcnt(satcnt0_v)
`endif
  );

`ifndef SAT_STEP_ARBITER_SATCNT_EN
  assign satcnt_v  = 8'h00;
  assign satcnt0_v = 8'h00;
`endif

  vec_t       tbl[$];
  vec_t       exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic add_row(input logic rn, input logic ra, input logic da, input logic rb,
                         input logic db, input logic ea, input logic eb,
                         input logic [3:0] lvl, input logic eb_busy, input logic es);
    vec_t v;
    v.idx = tbl.size(); v.rst_n = rn;
    v.ra = ra; v.da = da; v.rb = rb; v.db = db;
    v.ack_a = ea; v.ack_b = eb; v.level = lvl; v.busy = eb_busy; v.sat = es;
    v.cnt = exp_cnt;
    tbl.push_back(v);
  endtask

  // One complete step: request edge, then GRANT->HOLD->HOLD->IDLE.
  task automatic add_step(input logic ra, input logic da, input logic rb, input logic db,
                          input logic hold, input logic ea, input logic eb,
                          input logic [3:0] prev, input logic [3:0] nxt, input logic clip);
    logic ha, hb;
    ha = hold & ra;
    hb = hold & rb;
    add_row(1'b1, ra, da, rb, db, ea, eb, prev, 1'b1, 1'b0);
    if (clip) exp_cnt = exp_cnt + 8'd1;
    add_row(1'b1, ha, da, hb, db, 1'b0, 1'b0, nxt, 1'b1, clip);
    add_row(1'b1, ha, da, hb, db, 1'b0, 1'b0, nxt, 1'b1, 1'b0);
    add_row(1'b1, ha, da, hb, db, 1'b0, 1'b0, nxt, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t e;
    logic [9:0] act_o, exp_o;
    logic [3:0] lv [0:23];
    int         acks[$];
    logic       whos[$];

    // Reset held with a pending request
    add_row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add_row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
    for (int i = 1; i < 15; i++) begin
      if (i % 2 == 1)
        add_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), 4'(i + 1), 1'b0);
      else
        add_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i + 1), 1'b0);
    end
    add_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b1);
    for (int i = 15; i > 0; i--)
      add_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i - 1), 1'b0);
    add_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1);
    // Last single step by B leaves the pointer on A
    for (int i = 0; i < 7; i++)
      add_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), 4'(i + 1), 1'b0);
    // Contention, both held high: A, B, A, B, A
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd8, 1'b0);
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd7, 1'b0);
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd8, 1'b0);
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd7, 1'b0);
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd8, 1'b0);
    // B granted, then reset lands while the DUT is in GRANT
    add_row(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
    exp_cnt = 8'd0;
    add_row(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);

    for (int k = 0; k <= tbl.size(); k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_o = {ack_a, ack_b, level, busy, sat, at_min, at_max};
        exp_o = {e.ack_a, e.ack_b, e.level, e.busy, e.sat, (e.level == 4'd0), (e.level == 4'd15)};
        check($sformatf("row%0d {ackA,ackB,lvl,busy,sat,min,max}", e.idx), 32'(act_o), 32'(exp_o));
`ifdef SAT_STEP_ARBITER_SATCNT_EN
        check($sformatf("row%0d satcnt", e.idx), 32'(satcnt_v), 32'(e.cnt));
`endif
      end
      if (k < tbl.size()) begin
        rst_n = tbl[k].rst_n;
        req_a = tbl[k].ra; dir_a = tbl[k].da;
        req_b = tbl[k].rb; dir_b = tbl[k].db;
        exp_q.push_back(tbl[k]);
      end
    end

    // HOLDOFF = 0: continuous contention, grants every 2 cycles
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst_n0 = 1'b1; req_a0 = 1'b1; dir_a0 = 1'b1; req_b0 = 1'b1; dir_b0 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      lv[c] = level0;
      if (ack_a0 || ack_b0) begin
        acks.push_back(c);
        whos.push_back(ack_b0);
      end
    end
    check("h0 ack count>=4", 32'(acks.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < acks.size(); i++) begin
      check($sformatf("h0 grant%0d winnerB", i), 32'(whos[i]), 32'(i % 2));
      if (acks[i] + 1 < 24)
        check($sformatf("h0 grant%0d level", i), 32'(lv[acks[i] + 1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i + 1 < acks.size())
        check($sformatf("h0 gap%0d", i), 32'(acks[i + 1] - acks[i]), 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
